signal_analyzer: RTL and testbench

- Receive-side counterpart of the DAC signal generator. It consumes the ADC sample stream and detects rising edges of the received waveform using a hysteresis comparator.
- Over a configurable window of 2^N periods it measures the summed period length, in samples, and the peak-to-peak amplitude.
- Each window's result is emitted as one 64-bit AXI-Stream word, with backpressure handling and a dropped-result counter.
- Sits between the ADC input path and the PS-readable FIFO/register bank.

---
 rtl/signal_analyzer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_signal_analyzer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/signal_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : signal_analyzer
// Description : Rising-edge period and peak-to-peak analyser for the ADC
//               sample stream. A hysteresis comparator finds rising edges.
//               Over a window of 2^N periods the block sums the period
//               lengths and tracks min/max. It emits one 64-bit AXI-Stream
//               result per window, with a saturating dropped-result counter.
//               Optional macro SIGNAL_ANALYZER_OFFSET_EN enables a signed
//               comparator centre taken from cfg_data[47:32].
// Revision    : 1.0 - initial release
// ============================================================================
module signal_analyzer #(
    parameter int AXIS_TDATA_WIDTH     = 16,
    parameter int ADC_WIDTH            = 14,
    parameter int CFG_DATA_WIDTH       = 64,
    parameter int PERIOD_WIDTH         = 32,
    parameter int AXIS_TDATA_OUT_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic [CFG_DATA_WIDTH-1:0]       cfg_data,
    output logic [AXIS_TDATA_OUT_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [15:0]                     drop_count
);

    // Samples, centre and thresholds share an 18-bit signed domain so that
    // C+H and C-H can never wrap.
    localparam int XW = 18;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SYNC_LOW  = 3'd1,
        S_SYNC_RISE = 3'd2,
        S_RUN_HIGH  = 3'd3,
        S_RUN_LOW   = 3'd4
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic signed [XW-1:0]      r_x;
    logic                      r_xv;
    logic [PERIOD_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic [PERIOD_WIDTH-1:0]   r_acc, w_acc_nxt;
    logic [7:0]                r_periods, w_per_nxt;
    logic signed [XW-1:0]      r_min, w_min_nxt;
    logic signed [XW-1:0]      r_max, w_max_nxt;
    logic [2:0]                r_n, w_n_nxt;
    logic                      r_res_vld;
    logic [AXIS_TDATA_OUT_WIDTH-1:0] r_res_data;
    logic [AXIS_TDATA_OUT_WIDTH-1:0] r_m_tdata;
    logic                      r_m_tvalid;
    logic [15:0]               r_drop;

    logic signed [XW-1:0]      w_x_ext;
    logic signed [XW-1:0]      w_c;
    logic signed [XW-1:0]      w_h;
    logic signed [XW-1:0]      w_thr_hi;
    logic signed [XW-1:0]      w_thr_lo;
    logic                      w_hi, w_lo;
    logic                      w_en;
    logic [2:0]                w_n;
    logic signed [XW-1:0]      w_min_upd, w_max_upd;
    logic [XW-1:0]             w_p2p;
    logic [PERIOD_WIDTH-1:0]   w_cnt_inc;
    logic [PERIOD_WIDTH:0]     w_acc_sum;
    logic [PERIOD_WIDTH-1:0]   w_acc_sat;
    logic [7:0]                w_per_inc;
    logic [7:0]                w_target;
    logic                      w_emit;
    logic                      w_res_to;
    logic [PERIOD_WIDTH-1:0]   w_res_acc;
    logic [7:0]                w_res_per;
    logic [AXIS_TDATA_OUT_WIDTH-1:0] w_res_data;
    logic                      w_unused;

    assign w_x_ext  = {{(XW-ADC_WIDTH){s_axis_tdata[ADC_WIDTH-1]}}, s_axis_tdata[ADC_WIDTH-1:0]};
    assign w_h      = {2'b00, cfg_data[15:0]};
    assign w_en     = cfg_data[16];
    assign w_n      = cfg_data[19:17];

`ifdef SIGNAL_ANALYZER_OFFSET_EN
    assign w_c      = {{2{cfg_data[47]}}, cfg_data[47:32]};
    assign w_unused = ^{cfg_data[CFG_DATA_WIDTH-1:48], cfg_data[31:20],
                        s_axis_tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH], w_p2p[XW-1:16]};
`else
    assign w_c      = '0;
    assign w_unused = ^{cfg_data[CFG_DATA_WIDTH-1:20],
                        s_axis_tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH], w_p2p[XW-1:16]};
`endif

    assign w_thr_hi  = w_c + w_h;
    assign w_thr_lo  = w_c - w_h;
    assign w_hi      = (r_x >= w_thr_hi);
    assign w_lo      = (r_x <  w_thr_lo);

    // The completing sample belongs to the window it closes, so the result
    // uses min/max already updated with it.
    assign w_min_upd = (r_x < r_min) ? r_x : r_min;
    assign w_max_upd = (r_x > r_max) ? r_x : r_max;
    assign w_p2p     = w_max_upd - w_min_upd;

    assign w_cnt_inc = r_cnt + PERIOD_WIDTH'(1);
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_cnt_inc};
    assign w_acc_sat = w_acc_sum[PERIOD_WIDTH] ? '1 : w_acc_sum[PERIOD_WIDTH-1:0];
    assign w_per_inc = r_periods + 8'd1;
    assign w_target  = 8'd1 << r_n;

    assign w_res_data = AXIS_TDATA_OUT_WIDTH'({w_res_to, 7'd0, w_res_per, w_p2p[15:0], 32'(w_res_acc)});

    // Input stage: capture only qualified samples; the valid flag gates all counting downstream.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_x  <= '0;
            r_xv <= 1'b0;
        end else begin
            r_xv <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                r_x <= w_x_ext;
            end
        end
    end

    // FSM state and measurement registers, plus the one-deep result stage.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_periods  <= '0;
            r_min      <= '0;
            r_max      <= '0;
            r_n        <= '0;
            r_res_vld  <= 1'b0;
            r_res_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_acc      <= w_acc_nxt;
            r_periods  <= w_per_nxt;
            r_min      <= w_min_nxt;
            r_max      <= w_max_nxt;
            r_n        <= w_n_nxt;
            r_res_vld  <= w_emit;
            if (w_emit) begin
                r_res_data <= w_res_data;
            end
        end
    end

    // Next-state and datapath update; an edge in RUN_LOW takes priority over timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_per_nxt   = r_periods;
        w_min_nxt   = r_min;
        w_max_nxt   = r_max;
        w_n_nxt     = r_n;
        w_emit      = 1'b0;
        w_res_to    = 1'b0;
        w_res_acc   = r_acc;
        w_res_per   = r_periods;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_acc_nxt = '0;
                w_per_nxt = '0;
                w_min_nxt = '0;
                w_max_nxt = '0;
                if (w_en) begin
                    w_state_nxt = S_SYNC_LOW;
                end
            end
            S_SYNC_LOW: begin
                if (r_xv && w_lo) begin
                    w_state_nxt = S_SYNC_RISE;
                end
            end
            S_SYNC_RISE: begin
                if (r_xv && w_hi) begin
                    w_n_nxt     = w_n;
                    w_cnt_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_per_nxt   = '0;
                    w_min_nxt   = r_x;
                    w_max_nxt   = r_x;
                    w_state_nxt = S_RUN_HIGH;
                end
            end
            S_RUN_HIGH, S_RUN_LOW: begin
                if (r_xv) begin
                    w_min_nxt = w_min_upd;
                    w_max_nxt = w_max_upd;
                    if ((r_state == S_RUN_LOW) && w_hi) begin
                        w_cnt_nxt   = '0;
                        w_acc_nxt   = w_acc_sat;
                        w_per_nxt   = w_per_inc;
                        w_state_nxt = S_RUN_HIGH;
                        if (w_per_inc == w_target) begin
                            w_emit    = 1'b1;
                            w_res_acc = w_acc_sat;
                            w_res_per = w_per_inc;
                            w_n_nxt   = w_n;
                            w_acc_nxt = '0;
                            w_per_nxt = '0;
                            w_min_nxt = r_x;
                            w_max_nxt = r_x;
                        end
                    end else if (w_cnt_inc == '1) begin
                        w_emit      = 1'b1;
                        w_res_to    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_SYNC_LOW;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if ((r_state == S_RUN_HIGH) && w_lo) begin
                            w_state_nxt = S_RUN_LOW;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Disabling abandons the partial window, including a result completing this cycle.
        if (!w_en) begin
            w_state_nxt = S_IDLE;
            w_emit      = 1'b0;
        end
    end

    // Output register: hold until accepted; a result arriving while blocked is counted as dropped.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_drop     <= '0;
        end else begin
            if (r_res_vld) begin
                if (!r_m_tvalid || m_axis_tready) begin
                    r_m_tdata  <= r_res_data;
                    r_m_tvalid <= 1'b1;
                end else if (r_drop != 16'hFFFF) begin
                    r_drop <= r_drop + 16'd1;
                end
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign drop_count    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_signal_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : tb_signal_analyzer
// Description : Directed bench for signal_analyzer. A 32-bit instance covers
//               the windowing, backpressure and gap cases; an 8-bit-period
//               instance covers the timeout path on the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_analyzer;

    localparam logic [63:0] W1 = {1'b0, 7'd0, 8'd1, 16'd8000, 32'd100};
    localparam logic [63:0] W3 = {1'b0, 7'd0, 8'd8, 16'd8000, 32'd800};
    localparam logic [63:0] WT = {1'b1, 7'd0, 8'd0, 16'd0,    32'd0};

    logic        clk = 1'b0;
    logic        aresetn;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic [63:0] cfg;
    logic [63:0] m_tdata, m_tdata8;
    logic        m_tvalid, m_tvalid8;
    logic        tready, tready8;
    logic [15:0] drop, drop8;

    int checks = 0;
    int errors = 0;
    int phase  = 50;
    int ctr    = 0;
    logic [63:0] q32[$];
    logic [63:0] q8[$];

    always #4 clk = ~clk;

    signal_analyzer dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .cfg_data      (cfg),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (tready),
        .drop_count    (drop)
    );

    signal_analyzer #(.PERIOD_WIDTH(8)) dut8 (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .cfg_data      (cfg),
        .m_axis_tdata  (m_tdata8),
        .m_axis_tvalid (m_tvalid8),
        .m_axis_tready (tready8),
        .drop_count    (drop8)
    );

    // Record every word that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (m_tvalid && tready)   q32.push_back(m_tdata);
        if (m_tvalid8 && tready8) q8.push_back(m_tdata8);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic e, input logic [2:0] n);
        logic [15:0] off;
        off = 16'd1000;
        cfg = {16'h0000, off, 12'h000, n, e, 16'd100};
    endtask

    // One sample per clock edge; upper two bus bits carry junk that must be ignored.
    task automatic send(input int v, input logic vld);
        logic [13:0] v14;
        v14      = v[13:0];
        s_tdata  = {2'b10, v14};
        s_tvalid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic sq(input int n);
        for (int i = 0; i < n; i++) begin
            send((phase < 50) ? ctr + 4000 : ctr - 4000, 1'b1);
            phase = (phase + 1) % 100;
        end
    endtask

    task automatic restart(input logic [2:0] n);
        set_cfg(1'b0, n);
        for (int i = 0; i < 3; i++) send(ctr, 1'b1);
        q32.delete();
        q8.delete();
        phase = 50;
        set_cfg(1'b1, n);
    endtask

    initial begin
`ifdef SIGNAL_ANALYZER_OFFSET_EN
        ctr = 1000;
`else
        ctr = 0;
`endif
        aresetn  = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        tready   = 1'b1;
        tready8  = 1'b1;
        set_cfg(1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
        end
        #1;
        aresetn = 1'b1;
        chk("reset_tvalid", 64'(m_tvalid), 64'd0);
        chk("reset_tdata",  m_tdata,       64'd0);
        chk("reset_drop",   64'(drop),     64'd0);

        // N=0: first word two edges after the second rising edge, then every 100 samples
        restart(3'd0);
        sq(151);
        sq(1);
        chk("t2_latency_early", 64'(m_tvalid), 64'd0);
        sq(1);
        chk("t2_latency_valid", 64'(m_tvalid), 64'd1);
        chk("t2_first_word",    m_tdata,       W1);
        sq(302);
        chk("t2_word_count", 64'(q32.size()), 64'd4);
        foreach (q32[i]) chk($sformatf("t2_word%0d", i), q32[i], W1);
        chk("t2_drop", 64'(drop), 64'd0);

        // N=3: eight periods per word
        restart(3'd3);
        sq(2000);
        chk("t3_word_count", 64'(q32.size()), 64'd2);
        foreach (q32[i]) chk($sformatf("t3_word%0d", i), q32[i], W3);

        // Backpressure across three windows, then release
        tready = 1'b0;
        restart(3'd0);
        sq(400);
        chk("t4_held_valid", 64'(m_tvalid), 64'd1);
        chk("t4_held_word",  m_tdata,       W1);
        chk("t4_drop",       64'(drop),     64'd2);
        tready = 1'b1;
        sq(100);
        chk("t4_word_count", 64'(q32.size()), 64'd2);
        foreach (q32[i]) chk($sformatf("t4_word%0d", i), q32[i], W1);
        chk("t4_drop_after", 64'(drop), 64'd2);

        // Valid every other cycle; the gap samples carry the opposite level
        restart(3'd0);
        for (int i = 0; i < 400; i++) begin
            send((phase < 50) ? ctr + 4000 : ctr - 4000, 1'b1);
            send((phase < 50) ? ctr - 4000 : ctr + 4000, 1'b0);
            phase = (phase + 1) % 100;
        end
        chk("t5_word_count", 64'(q32.size()), 64'd3);
        foreach (q32[i]) chk($sformatf("t5_word%0d", i), q32[i], W1);

        // Enable dropped mid-window discards it; re-enable resynchronises
        restart(3'd0);
        sq(101);
        set_cfg(1'b0, 3'd0);
        sq(10);
        chk("t6_no_word",   64'(q32.size()), 64'd0);
        chk("t6_no_valid",  64'(m_tvalid),   64'd0);
        restart(3'd0);
        sq(200);
        chk("t6_word_count", 64'(q32.size()), 64'd1);
        chk("t6_word", (q32.size() > 0) ? q32[0] : 64'd0, W1);

        // Small toggling stays in sync; then a single edge and a flat level times out
        restart(3'd0);
        for (int i = 0; i < 200; i++) send(((i % 2) != 0) ? ctr + 50 : ctr - 50, 1'b1);
        chk("t7_sync_none32", 64'(q32.size()), 64'd0);
        chk("t7_sync_none8",  64'(q8.size()),  64'd0);
        send(ctr - 4000, 1'b1);
        send(ctr + 4000, 1'b1);
        for (int i = 0; i < 255; i++) send(ctr + 4000, 1'b1);
        chk("t7_to_early0", 64'(m_tvalid8), 64'd0);
        send(ctr + 4000, 1'b1);
        chk("t7_to_early1", 64'(m_tvalid8), 64'd0);
        send(ctr + 4000, 1'b1);
        chk("t7_to_valid",  64'(m_tvalid8), 64'd1);
        chk("t7_to_word",   m_tdata8,       WT);
        chk("t7_none32",    64'(q32.size()), 64'd0);

        // Reset mid-operation clears output and drop counter
        aresetn = 1'b0;
        send(ctr + 4000, 1'b1);
        aresetn = 1'b1;
        chk("mid_reset_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid_reset_tdata",  m_tdata,       64'd0);
        chk("mid_reset_drop",   64'(drop),     64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
